tt_mux_ctrl: RTL and testbench

Project-side controller that drives the shared 18-bit `iw` input bus and collects the 24-bit `ow` output words of the per-project wrappers. It sits between the chip pads and the array of project wrappers. It selects one project through a pad-driven counter and sequences that project's `ena` through a settle window. It fans the pad inputs out onto `iw` and muxes the selected project's `ow` back to the pads.

---
 rtl/tt_mux_pkg.sv | 30 +++
 rtl/tt_mux_if.sv | 15 +
 rtl/tt_sync_edge.sv | 32 +++
 rtl/tt_mux_ctrl.sv | 153 +++++++++++++++
 tb/tb_tt_mux_ctrl.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tt_mux_pkg.sv
// Shared widths, bus field offsets and controller state type for the project mux.
// Everything that touches iw/ow words imports this package.
package tt_mux_pkg;

  localparam int IW_W = 18;
  localparam int OW_W = 24;

  localparam int IW_CLK     = 0;
  localparam int IW_RST_N   = 1;
  localparam int IW_UI_LSB  = 2;
  localparam int IW_UIO_LSB = 10;

  localparam int OW_UO_LSB  = 0;
  localparam int OW_UIO_LSB = 8;
  localparam int OW_OE_LSB  = 16;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    SETTLE = 2'd1,
    ON     = 2'd2
  } mux_state_t;

  function automatic logic [IW_W-1:0] pack_iw(input logic [7:0] uio_in,
                                              input logic [7:0] ui_in,
                                              input logic       rst_n,
                                              input logic       clk);
    return {uio_in, ui_in, rst_n, clk};
  endfunction

endpackage

// File: rtl/tt_mux_if.sv
// Project-side bus between the mux controller (master) and the wrapper array (slave).
// No valid/ready: ena is one-hot or zero, and iw is all-zero (projects held in reset) unless a project is live.
interface tt_mux_if #(
  parameter int NUM_PROJ = 16
);
  import tt_mux_pkg::*;

  logic [IW_W-1:0]          iw;
  logic [NUM_PROJ-1:0]      ena;
  logic [NUM_PROJ*OW_W-1:0] ow_all;

  modport master (output iw, output ena, input ow_all);
  modport slave  (input iw, input ena, output ow_all);

endinterface

// File: rtl/tt_sync_edge.sv
// Two-flop synchroniser for an asynchronous pad level, with an optional
// rising-edge pulse taken from a third flop behind the synchronised value.
module tt_sync_edge #(
  parameter bit EDGE_EN = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= EDGE_EN ? s2 : 1'b0;
    end
  end

  assign q    = s2;
  assign rise = EDGE_EN ? (s2 & ~s3) : 1'b0;

endmodule

// File: rtl/tt_mux_ctrl.sv
// Project selection and enable sequencer: fans pad inputs onto iw, enables one
// wrapper after a settle window, and returns the selected wrapper's outputs to the pads.
module tt_mux_ctrl
  import tt_mux_pkg::*;
#(
  parameter int NUM_PROJ   = 16,
  parameter int SEL_W      = 4,
  parameter int SETTLE_CYC = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ctrl_sel_rst,
  input  logic             ctrl_sel_inc,
  input  logic             ctrl_ena,
  input  logic             pad_clk,
  input  logic             pad_rst_n,
  input  logic [7:0]       pad_ui_in,
  input  logic [7:0]       pad_uio_in,
  tt_mux_if.master         proj,
  output logic [7:0]       pad_uo_out,
  output logic [7:0]       pad_uio_out,
  output logic [7:0]       pad_uio_oe,
  output logic [SEL_W-1:0] sel,
  output mux_state_t       state_dbg
);

  localparam int                CNT_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [SEL_W-1:0]  SEL_LAST = SEL_W'(NUM_PROJ - 1);

  logic sel_rst_s;
  logic ena_s;
  logic inc_s;
  logic inc_rise;
  logic sel_rst_rise_unused;
  logic ena_rise_unused;

  tt_sync_edge #(.EDGE_EN(1'b0)) u_sync_sel_rst (
    .clk (clk), .rst (rst), .d (ctrl_sel_rst), .q (sel_rst_s), .rise (sel_rst_rise_unused)
  );

  tt_sync_edge #(.EDGE_EN(1'b1)) u_sync_sel_inc (
    .clk (clk), .rst (rst), .d (ctrl_sel_inc), .q (inc_s), .rise (inc_rise)
  );

  tt_sync_edge #(.EDGE_EN(1'b0)) u_sync_ena (
    .clk (clk), .rst (rst), .d (ctrl_ena), .q (ena_s), .rise (ena_rise_unused)
  );

  mux_state_t           state_q;
  mux_state_t           state_nx;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_nx;
  logic [SEL_W-1:0]     sel_q;
  logic [SEL_W-1:0]     sel_nx;
  logic                 sel_chg;
  logic [NUM_PROJ-1:0]  ena_q;
  logic [NUM_PROJ-1:0]  ena_nx;
  logic [OW_W-1:0]      ow_sel;
  logic [OW_W-1:0]      pad_word_q;
  logic                 live;

  // sel_rst has priority, so an inc edge that coincides with it is dropped.
  always_comb begin
    sel_nx = sel_q;
    if (sel_rst_s) begin
      sel_nx = '0;
    end else if (inc_rise) begin
      sel_nx = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
    end
  end

  // Treat the inc edge itself as the selection change so the enable drops on
  // the same edge sel moves, never leaving the old bit high beside the new one.
  assign sel_chg = sel_rst_s | inc_rise;

  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q;
    unique case (state_q)
      OFF: begin
        if (ena_s && !sel_rst_s) begin
          state_nx = SETTLE;
          cnt_nx   = CNT_LOAD;
        end
      end
      SETTLE: begin
        if (!ena_s || sel_chg) begin
          state_nx = OFF;
          cnt_nx   = '0;
        end else if (cnt_q == '0) begin
          state_nx = ON;
        end else begin
          cnt_nx = cnt_q - 1'b1;
        end
      end
      ON: begin
        if (!ena_s || sel_chg) begin
          state_nx = OFF;
        end
      end
      default: begin
        state_nx = OFF;
        cnt_nx   = '0;
      end
    endcase
  end

  always_comb begin
    ena_nx = '0;
    for (int k = 0; k < NUM_PROJ; k++) begin
      ena_nx[k] = (state_nx == ON) && (sel_nx == SEL_W'(k));
    end
  end

  always_comb begin
    ow_sel = '0;
    for (int k = 0; k < NUM_PROJ; k++) begin
      if (sel_q == SEL_W'(k)) begin
        ow_sel = proj.ow_all[k*OW_W +: OW_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= OFF;
      cnt_q      <= '0;
      sel_q      <= '0;
      ena_q      <= '0;
      pad_word_q <= '0;
    end else begin
      state_q    <= state_nx;
      cnt_q      <= cnt_nx;
      sel_q      <= sel_nx;
      ena_q      <= ena_nx;
      // Zero on the leaving edge too, so uio_oe never outlives the enable.
      pad_word_q <= (state_q == ON && state_nx == ON) ? ow_sel : '0;
    end
  end

  assign live      = (state_q == ON);
  assign proj.iw   = live ? pack_iw(pad_uio_in, pad_ui_in, pad_rst_n, pad_clk) : '0;
  assign proj.ena  = ena_q;

  assign pad_uo_out  = pad_word_q[OW_UO_LSB  +: 8];
  assign pad_uio_out = pad_word_q[OW_UIO_LSB +: 8];
  assign pad_uio_oe  = pad_word_q[OW_OE_LSB  +: 8];

  assign sel       = sel_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_tt_mux_ctrl.sv
// Bench for tt_mux_ctrl: directed sequences for selection/sequencing corners and
// a vector table plus random words checked through an expected-output queue.
module tb_tt_mux_ctrl;
  import tt_mux_pkg::*;

  localparam int NUM_PROJ   = 16;
  localparam int SEL_W      = 4;
  localparam int SETTLE_CYC = 8;

  logic                   clk;
  logic                   rst;
  logic                   ctrl_sel_rst;
  logic                   ctrl_sel_inc;
  logic                   ctrl_ena;
  logic                   pad_clk;
  logic                   pad_rst_n;
  logic [7:0]             pad_ui_in;
  logic [7:0]             pad_uio_in;
  logic [7:0]             pad_uo_out;
  logic [7:0]             pad_uio_out;
  logic [7:0]             pad_uio_oe;
  logic [SEL_W-1:0]       sel;
  mux_state_t             state_dbg;
  logic [NUM_PROJ*24-1:0] ow_all;

  tt_mux_if #(.NUM_PROJ(NUM_PROJ)) bus ();
  assign bus.ow_all = ow_all;

  tt_mux_ctrl #(
    .NUM_PROJ   (NUM_PROJ),
    .SEL_W      (SEL_W),
    .SETTLE_CYC (SETTLE_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ctrl_sel_rst (ctrl_sel_rst),
    .ctrl_sel_inc (ctrl_sel_inc),
    .ctrl_ena     (ctrl_ena),
    .pad_clk      (pad_clk),
    .pad_rst_n    (pad_rst_n),
    .pad_ui_in    (pad_ui_in),
    .pad_uio_in   (pad_uio_in),
    .proj         (bus),
    .pad_uo_out   (pad_uo_out),
    .pad_uio_out  (pad_uio_out),
    .pad_uio_oe   (pad_uio_oe),
    .sel          (sel),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int onehot_err = 0;
  logic [23:0] exp_q[$];

  always @(negedge clk) begin
    if ($countones(bus.ena) > 1) onehot_err++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [7:0] ui;
    logic [7:0] uio;
    logic       rst_n;
    logic       pclk;
    logic [7:0] uo_o;
    logic [7:0] uio_o;
    logic [7:0] oe_o;
  } vec_t;

  vec_t vecs[5];

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic inc_pulse();
    ctrl_sel_inc = 1'b1;
    tick(3);
    ctrl_sel_inc = 1'b0;
    tick(3);
  endtask

  task automatic set_word(input int k, input logic [23:0] w);
    ow_all[k*24 +: 24] = w;
  endtask

  task automatic drive_word(input logic [23:0] w);
    set_word(5, w);
    set_word(4, ~w);
    set_word(6, ~w);
    exp_q.push_back(w);
  endtask

  task automatic check_pads(input string name);
    logic [23:0] exp;
    if (exp_q.size() == 0) begin
      chk({name, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      exp = exp_q.pop_front();
      chk(name, {pad_uio_oe, pad_uio_out, pad_uo_out}, exp);
    end
  endtask

  initial begin
    int zeros;
    logic [23:0] w;

    vecs[0] = '{8'h12, 8'h34, 1'b1, 1'b0, 8'h00, 8'hFF, 8'h00};
    vecs[1] = '{8'hFF, 8'h00, 1'b0, 1'b1, 8'h5A, 8'hC3, 8'hFF};
    vecs[2] = '{8'h80, 8'h01, 1'b1, 1'b1, 8'h01, 8'h80, 8'h7E};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h81};
    vecs[4] = '{8'hA5, 8'h5A, 1'b1, 1'b0, 8'h3C, 8'h96, 8'h69};

    for (int k = 0; k < NUM_PROJ; k++) set_word(k, 24'($urandom_range(0, 32'h00FF_FFFF)));

    // Reset with every pad high
    rst = 1'b1;
    ctrl_sel_rst = 1'b1; ctrl_sel_inc = 1'b1; ctrl_ena = 1'b1;
    pad_clk = 1'b1; pad_rst_n = 1'b1; pad_ui_in = 8'hFF; pad_uio_in = 8'hFF;
    tick(3);
    chk("rst_ena", bus.ena, 32'h0);
    chk("rst_iw", bus.iw, 32'h0);
    chk("rst_pads", {pad_uio_oe, pad_uio_out, pad_uo_out}, 32'h0);
    chk("rst_sel", sel, 32'h0);
    chk("rst_state", state_dbg, OFF);
    ctrl_sel_rst = 1'b0; ctrl_sel_inc = 1'b0; ctrl_ena = 1'b0;
    rst = 1'b0;
    tick(4);
    chk("post_rst_state", state_dbg, OFF);

    // Select project 5 and enable it
    repeat (5) inc_pulse();
    chk("sel_5", sel, 32'd5);
    set_word(5, 24'hA53CF0);
    pad_ui_in = 8'hC3; pad_uio_in = 8'h81; pad_rst_n = 1'b1; pad_clk = 1'b1;
    ctrl_ena = 1'b1;
    tick(2);
    for (int i = 0; i < SETTLE_CYC; i++) begin
      tick(1);
      chk("settle_ena_low", bus.ena, 32'h0);
    end
    chk("settle_iw_low", bus.iw, 32'h0);
    tick(1);
    chk("on_ena", bus.ena, 32'h0020);
    chk("on_iw", bus.iw, {8'h81, 8'hC3, 1'b1, 1'b1});
    tick(1);
    chk("on_uo", pad_uo_out, 32'hF0);
    chk("on_uio", pad_uio_out, 32'h3C);
    chk("on_oe", pad_uio_oe, 32'hA5);

    // Table vectors while project 5 is live
    foreach (vecs[i]) begin
      pad_ui_in  = vecs[i].ui;
      pad_uio_in = vecs[i].uio;
      pad_rst_n  = vecs[i].rst_n;
      pad_clk    = vecs[i].pclk;
      drive_word({vecs[i].oe_o, vecs[i].uio_o, vecs[i].uo_o});
      #1;
      chk("vec_iw", bus.iw, {vecs[i].uio, vecs[i].ui, vecs[i].rst_n, vecs[i].pclk});
      tick(1);
      check_pads("vec_pads");
    end

    for (int i = 0; i < 6; i++) begin
      w = 24'($urandom_range(0, 32'h00FF_FFFF));
      drive_word(w);
      tick(1);
      check_pads("rand_pads");
    end

    // Drop ena: falls on the 3rd edge from the pad
    ctrl_ena = 1'b0;
    tick(2);
    chk("drop_ena_held", bus.ena, 32'h0020);
    tick(1);
    chk("drop_ena", bus.ena, 32'h0);
    chk("drop_pads", {pad_uio_oe, pad_uio_out, pad_uo_out}, 32'h0);
    chk("drop_iw", bus.iw, 32'h0);

    // Wrap: 17 increments from 0
    ctrl_sel_rst = 1'b1;
    tick(3);
    chk("selrst_sel", sel, 32'd0);
    ctrl_sel_rst = 1'b0;
    tick(3);
    repeat (17) inc_pulse();
    chk("wrap_sel", sel, 32'd1);

    // Reselect while project 2 is on
    inc_pulse();
    chk("sel_2", sel, 32'd2);
    ctrl_ena = 1'b1;
    tick(2 + 1 + SETTLE_CYC);
    chk("p2_ena", bus.ena, 32'h0004);
    ctrl_sel_inc = 1'b1;
    tick(2);
    chk("resel_ena_held", bus.ena, 32'h0004);
    tick(1);
    chk("resel_ena_off", bus.ena, 32'h0);
    chk("resel_sel", sel, 32'd3);
    ctrl_sel_inc = 1'b0;
    zeros = 1;
    for (int i = 0; i < 20 && bus.ena == '0; i++) begin
      tick(1);
      if (bus.ena == '0) zeros++;
    end
    chk("resel_zero_cycles", zeros, SETTLE_CYC + 1);
    chk("resel_ena_p3", bus.ena, 32'h0008);

    // Collision of sel_rst and an inc edge at sel=7
    repeat (4) inc_pulse();
    chk("sel_7", sel, 32'd7);
    ctrl_sel_rst = 1'b1;
    ctrl_sel_inc = 1'b1;
    tick(3);
    chk("coll_sel", sel, 32'd0);
    chk("coll_state", state_dbg, OFF);
    chk("coll_ena", bus.ena, 32'h0);
    ctrl_sel_rst = 1'b0;
    ctrl_sel_inc = 1'b0;
    ctrl_ena = 1'b0;
    tick(4);
    chk("coll_sel_after", sel, 32'd0);

    // Reset during SETTLE with count at 3
    ctrl_ena = 1'b1;
    tick(3);
    tick(4);
    chk("mid_settle_state", state_dbg, SETTLE);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_state", state_dbg, OFF);
    chk("mid_rst_ena", bus.ena, 32'h0);
    chk("mid_rst_iw", bus.iw, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 2 + SETTLE_CYC; i++) begin
      tick(1);
      chk("mid_rst_wait", bus.ena, 32'h0);
    end
    tick(1);
    chk("mid_rst_on", bus.ena, 32'h0001);

    chk("onehot", onehot_err, 32'd0);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
